// File: rtl/trg_out_pkg.sv
// Shared types and defaults for the N-channel trigger output controller.
// Holds the FSM state encoding, mode encodings and the dead-time product helper.
package trg_out_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_WAIT_BUSY,
    ST_ARMED,
    ST_SEND_TRG,
    ST_CHK_GAP,
    ST_SEND_CHK
  } state_t;

  typedef enum logic [1:0] {
    MODE_BUSY_CHK = 2'b00,
    MODE_FIXED_DT = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_ALIAS    = 2'b11
  } mode_t;

  localparam int unsigned DEF_N_OUT    = 16;
  localparam int unsigned DEF_N_BUSY   = 2;
  localparam int unsigned DEF_TRG_PW   = 20;
  localparam int unsigned DEF_CHK_GAP  = 10;
  localparam int unsigned DEF_CHK_PW   = 50;
  localparam int unsigned DEF_CHK_LOG2 = 12;
  localparam int unsigned DEF_DT_UNIT  = 500;
  localparam int unsigned TMR_W        = 20;

  // 255 * 500 fits in 20 bits, so the product is exact at the default unit.
  function automatic logic [TMR_W-1:0] dt_cycles(input logic [7:0] t,
                                                  input logic [TMR_W-1:0] unit);
    return {{(TMR_W-8){1'b0}}, t} * unit;
  endfunction

endpackage

// File: rtl/trg_out_ctrl_nch_if.sv
// Control/status bundle of the trigger output controller.
// slave is the controller's view, master the driving environment's view.
interface trg_out_ctrl_nch_if #(
  parameter int unsigned N_OUT  = trg_out_pkg::DEF_N_OUT,
  parameter int unsigned N_BUSY = trg_out_pkg::DEF_N_BUSY
) ();

  logic [2:0]        trg_src_in;
  logic [2:0]        trg_src_mask_in;
  logic [N_BUSY-1:0] busy_syn_in;
  logic [N_BUSY-1:0] busy_mask_in;
  logic              pmu_busy_in;
  logic [1:0]        mode_in;
  logic              trg_enb_in;
  logic [7:0]        dead_time_in;
  logic [7:0]        burst_time_in;
  logic [N_OUT-1:0]  out_enb_in;
  logic              cnt_clr_in;
  logic              eff_trg_out;
  logic [15:0]       eff_trg_cnt_out;
  logic [15:0]       lost_trg_cnt_out;
  logic              busy_out;
  logic [N_OUT-1:0]  trg_out_N;

  modport slave (
    input  trg_src_in, trg_src_mask_in, busy_syn_in, busy_mask_in, pmu_busy_in,
           mode_in, trg_enb_in, dead_time_in, burst_time_in, out_enb_in, cnt_clr_in,
    output eff_trg_out, eff_trg_cnt_out, lost_trg_cnt_out, busy_out, trg_out_N
  );

  modport master (
    output trg_src_in, trg_src_mask_in, busy_syn_in, busy_mask_in, pmu_busy_in,
           mode_in, trg_enb_in, dead_time_in, burst_time_in, out_enb_in, cnt_clr_in,
    input  eff_trg_out, eff_trg_cnt_out, lost_trg_cnt_out, busy_out, trg_out_N
  );

endinterface

// File: rtl/trg_dead_timer.sv
// 20-bit elapsed-cycle timer shared by the dead time and the pulse-width phases.
// The limit is compared live every cycle, so it may change while counting.
module trg_dead_timer
  import trg_out_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_clr,
  input  logic [TMR_W-1:0] i_limit,
  output logic             o_done
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts cycles already spent; a limit of 0 behaves like 1.
  assign o_done = ({1'b0, r_cnt} + (TMR_W+1)'(1)) >= {1'b0, i_limit};

endmodule

// File: rtl/trg_out_ctrl_nch.sv
// Trigger output controller: qualifies trigger sources against busy/dead time,
// emits active-low trigger pulses plus a periodic check pulse, and counts triggers.
module trg_out_ctrl_nch
  import trg_out_pkg::*;
#(
  parameter int unsigned N_OUT    = DEF_N_OUT,
  parameter int unsigned N_BUSY   = DEF_N_BUSY,
  parameter int unsigned TRG_PW   = DEF_TRG_PW,
  parameter int unsigned CHK_GAP  = DEF_CHK_GAP,
  parameter int unsigned CHK_PW   = DEF_CHK_PW,
  parameter int unsigned CHK_LOG2 = DEF_CHK_LOG2,
  parameter int unsigned DT_UNIT  = DEF_DT_UNIT
) (
  input logic               clk_in,
  input logic               rst_in,
  trg_out_ctrl_nch_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_after;
  mode_t            w_mode;
  logic             r_src0_d;
  logic             r_eff_trg;
  logic             r_busy;
  logic [15:0]      r_eff_cnt;
  logic [15:0]      r_lost_cnt;
  logic [N_OUT-1:0] r_trg_n;
  logic [N_OUT-1:0] w_out_enb;
  logic             w_fire;
  logic             w_ready;
  logic             w_chk_due;
  logic             w_take_trg;
  logic             w_pulse_nxt;
  logic             w_tmr_clr;
  logic             w_tmr_done;
  logic [TMR_W-1:0] w_tmr_limit;

  assign w_mode    = mode_t'(bus.mode_in);
  assign w_out_enb = bus.out_enb_in;

  assign w_fire = (bus.trg_src_in[0] & ~r_src0_d & bus.trg_src_mask_in[0])
                | (bus.trg_src_in[1] & bus.trg_src_mask_in[1])
                | (bus.trg_src_in[2] & bus.trg_src_mask_in[2]);

  assign w_ready = ~bus.pmu_busy_in
                 & ((w_mode == MODE_FIXED_DT) | (w_mode == MODE_BURST)
                    | ~|(bus.busy_syn_in & bus.busy_mask_in));

  assign w_chk_due = (r_eff_cnt[CHK_LOG2-1:0] == '0);
  assign w_after   = bus.trg_enb_in ? ST_DEAD : ST_IDLE;

  always_comb begin
    w_tmr_limit = '0;
    case (r_state)
      ST_DEAD: begin
        if (w_mode == MODE_FIXED_DT) begin
          w_tmr_limit = dt_cycles(bus.dead_time_in, TMR_W'(DT_UNIT));
        end else if (w_mode == MODE_BURST) begin
          w_tmr_limit = dt_cycles(bus.burst_time_in, TMR_W'(DT_UNIT));
        end
      end
      ST_SEND_TRG: w_tmr_limit = TMR_W'(TRG_PW);
      ST_CHK_GAP:  w_tmr_limit = TMR_W'(CHK_GAP);
      ST_SEND_CHK: w_tmr_limit = TMR_W'(CHK_PW);
      default:     w_tmr_limit = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (bus.trg_enb_in) w_state_nxt = ST_DEAD;
      ST_DEAD:      if (w_tmr_done) w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (w_ready) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!bus.trg_enb_in)  w_state_nxt = ST_IDLE;
        else if (!w_ready)    w_state_nxt = ST_WAIT_BUSY;
        else if (w_fire)      w_state_nxt = ST_SEND_TRG;
      end
      ST_SEND_TRG:  if (w_tmr_done) w_state_nxt = w_chk_due ? ST_CHK_GAP : w_after;
      ST_CHK_GAP:   if (w_tmr_done) w_state_nxt = ST_SEND_CHK;
      ST_SEND_CHK:  if (w_tmr_done) w_state_nxt = w_after;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_take_trg  = (r_state == ST_ARMED) && (w_state_nxt == ST_SEND_TRG);
  assign w_pulse_nxt = (w_state_nxt == ST_SEND_TRG) || (w_state_nxt == ST_SEND_CHK);
  assign w_tmr_clr   = (w_state_nxt != r_state);

  trg_dead_timer u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_clr   (w_tmr_clr),
    .i_limit (w_tmr_limit),
    .o_done  (w_tmr_done)
  );

  // Outputs are registered from the next state so the pulse lines up with the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_src0_d   <= 1'b0;
      r_eff_trg  <= 1'b0;
      r_busy     <= 1'b0;
      r_trg_n    <= '1;
      r_eff_cnt  <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_src0_d  <= bus.trg_src_in[0];
      r_eff_trg <= w_take_trg;
      r_busy    <= !((w_state_nxt == ST_ARMED) || (w_state_nxt == ST_IDLE));
      r_trg_n   <= ~({N_OUT{w_pulse_nxt}} & w_out_enb);
      if (bus.cnt_clr_in) begin
        r_eff_cnt  <= '0;
        r_lost_cnt <= '0;
      end else begin
        if (w_take_trg) begin
          r_eff_cnt <= r_eff_cnt + 16'd1;
        end
        if (w_fire && bus.trg_enb_in && !w_take_trg && (r_lost_cnt != '1)) begin
          r_lost_cnt <= r_lost_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.eff_trg_out      = r_eff_trg;
  assign bus.eff_trg_cnt_out  = r_eff_cnt;
  assign bus.lost_trg_cnt_out = r_lost_cnt;
  assign bus.busy_out         = r_busy;
  assign bus.trg_out_N        = r_trg_n;

endmodule

// File: doc/trg_out_ctrl_nch.md
TRG_OUT_CTRL_NCH -- requirements
Module: trg_out_ctrl_nch

Interface
REQ-001 SHALL have parameter N_OUT, default 16, number of active-low trigger output lines.
REQ-002 SHALL have parameter N_BUSY, default 2, number of detector busy inputs.
REQ-003 SHALL have parameters TRG_PW=20, CHK_GAP=10, CHK_PW=50 (cycles), CHK_LOG2=12 (check-pulse period 2^CHK_LOG2), DT_UNIT=500 (cycles per dead-time LSB).
REQ-004 SHALL have the following ports: clk_in  in  1  system clock, 50 MHz; one clock only.
REQ-005 SHALL have: rst_in  in  1  reset, synchronous, active-high.
REQ-006 SHALL have: trg_src_in  in  3  [0] coincidence (edge-qualified), [1] external sync, [2] cycled (level).
REQ-007 SHALL have: trg_src_mask_in  in  3  1 = source enabled.
REQ-008 SHALL have: busy_syn_in / busy_mask_in  in  N_BUSY each  detector busy; mask 1 = honoured.
REQ-009 SHALL have: pmu_busy_in  in  1  PMU busy, always honoured.
REQ-010 SHALL have: mode_in  in  2  00 busy-check, 01 ignore-busy fixed dead time, 10 burst, 11 treated as 00.
REQ-011 SHALL have: trg_enb_in  in  1  global enable.
REQ-012 SHALL have: dead_time_in / burst_time_in  in  8 each  dead time for modes 01 / 10, in DT_UNIT steps.
REQ-013 SHALL have: out_enb_in  in  N_OUT  per-line enable; 0 holds that line high.
REQ-014 SHALL have: cnt_clr_in  in  1  synchronous clear of both counters.
REQ-015 SHALL have these outputs: eff_trg_out 1 (one-cycle effective-trigger pulse), eff_trg_cnt_out 16 (trigger ID), lost_trg_cnt_out 16 (rejected triggers), busy_out 1, trg_out_N N_OUT (active-low trigger/check pulses).

Function
REQ-016 SHALL define fire = (src[0] & ~src0_d & mask[0]) | (src[1] & mask[1]) | (src[2] & mask[2]), where src0_d is src[0] registered.
REQ-017 SHALL define ready = ~pmu_busy_in & (mode_in==01 | mode_in==10 | ~|(busy_syn_in & busy_mask_in)).
REQ-018 SHALL implement states IDLE, DEAD, WAIT_BUSY, ARMED, SEND_TRG, CHK_GAP, SEND_CHK.
REQ-019 IDLE SHALL go to DEAD when trg_enb_in=1.
REQ-020 DEAD SHALL clear the timer on entry.
- Modes 00/11: DEAD SHALL exit to WAIT_BUSY after exactly 1 cycle.
- Modes 01/10: DEAD SHALL exit after max(1, T*DT_UNIT) cycles, where T = dead_time_in (01) or burst_time_in (10).
- The product SHALL be computed in 20 bits without truncation.
REQ-021 WAIT_BUSY SHALL go to ARMED on the cycle ready=1.
REQ-022 ARMED SHALL:
- go to IDLE if trg_enb_in=0;
- otherwise go to WAIT_BUSY if ready=0;
- otherwise, if fire=1, go to SEND_TRG.
REQ-023 On an ARMED->SEND_TRG transition, the next cycle SHALL have:
- eff_trg_out=1 for exactly 1 cycle;
- eff_trg_cnt_out incremented, wrapping 0xFFFF->0x0000.
REQ-024 The internal pulse SHALL be high for exactly TRG_PW cycles in SEND_TRG, starting the cycle eff_trg_out=1.
REQ-025 After SEND_TRG, the FSM SHALL:
- go to CHK_GAP if eff_trg_cnt_out[CHK_LOG2-1:0]==0 (post-increment value);
- otherwise go to DEAD, or to IDLE if trg_enb_in=0.
REQ-026 CHK_GAP SHALL hold the pulse low for CHK_GAP cycles.
REQ-027 SEND_CHK SHALL drive the pulse high for CHK_PW cycles, then go to DEAD/IDLE per REQ-025.
REQ-028 trg_out_N[k] SHALL be registered, equal to ~(pulse & out_enb_in[k]), with no extra latency relative to the pulse.
REQ-029 busy_out SHALL be 1 in every state except ARMED and IDLE.
REQ-030 lost_trg_cnt_out SHALL increment when fire=1 & trg_enb_in=1 and the FSM is not taking ARMED->SEND_TRG; it SHALL saturate at 0xFFFF.
REQ-031 cnt_clr_in SHALL zero both counters next cycle, with priority over a simultaneous increment; FSM unaffected.
REQ-032 Parameter or input changes mid-DEAD SHALL take effect on the next timer compare.
REQ-033 trg_enb_in falling SHALL NOT truncate an active trigger or check pulse.

Reset
REQ-034 While rst_in=1, all registers SHALL take reset values: state IDLE, all counters 0, eff_trg_out=0, busy_out=0, trg_out_N all 1, src0_d=0.
REQ-035 Reset asserted mid-pulse SHALL force trg_out_N high on the next edge.

Structure
REQ-036 Package trg_out_pkg SHALL hold the state encoding, the mode encodings, and the default parameter constants.
REQ-037 Sub-module trg_dead_timer SHALL provide the 20-bit load/count/done timer for DEAD and the pulse-width counting.

Verification
REQ-038 Mode 00, busy_syn_in=01 with mask 11, coincid edge -> no pulse, lost_trg_cnt_out=1; after busy clears, next edge -> eff_trg_out 1 cycle, trg_out_N low 20 cycles.
REQ-039 Mode 01, dead_time_in=2, back-to-back cycled triggers -> trigger spacing = 20 + 1000 + (WAIT_BUSY/ARMED) cycles, verified exactly.
REQ-040 CHK_LOG2=2: 4th trigger -> 20 low, 10 high, 50 low on trg_out_N; eff_trg_cnt_out=4.
REQ-041 out_enb_in=0x0001 -> only trg_out_N[0] pulses; others stay high.
REQ-042 Coincid held high 100 cycles -> exactly one trigger.
REQ-043 rst_in during SEND_CHK -> outputs return to reset values next cycle; cnt_clr_in coincident with a trigger -> counter reads 0.
